// File: rtl/mul_m5_writeback.sv
// Multiply pipeline writeback stage: a DEPTH-entry skid FIFO between the M4 register and the ROB write port.
// Define MUL_WB_PERF_EN to add the saturating perf_stall_cycles / perf_wb_count counters.
module mul_m5_writeback #(
    parameter int WORD_SIZE       = 32,
    parameter int INSTR_TYPE_SZ   = 2,
    parameter int ROB_ENTRY_WIDTH = 3,
    parameter int DEPTH           = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [INSTR_TYPE_SZ-1:0]   in_type,
    input  logic [WORD_SIZE-1:0]       in_pc,
    input  logic [WORD_SIZE-1:0]       in_result,
    input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
    output logic                       stall_out,
    output logic                       wb_valid,
    output logic [INSTR_TYPE_SZ-1:0]   wb_type,
    output logic [WORD_SIZE-1:0]       wb_pc,
    output logic [WORD_SIZE-1:0]       wb_result,
    output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
`ifdef MUL_WB_PERF_EN
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_wb_count,
`endif
    input  logic                       wb_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0]   typ;
        logic [WORD_SIZE-1:0]       pc;
        logic [WORD_SIZE-1:0]       result;
        logic [ROB_ENTRY_WIDTH-1:0] rob_id;
    } entry_t;

    entry_t             mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               stall_r;
    logic               valid_r;
    logic               push_s;
    logic               pop_s;
    entry_t             in_entry_s;
    entry_t             head_s;
    entry_t             out_s;

    // stall_r gates push, so held in_* is never sampled while FULL (even if a pop happens this cycle)
    assign push_s = in_valid & ~stall_r;
    assign pop_s  = valid_r & wb_ready;

    assign in_entry_s.typ    = in_type;
    assign in_entry_s.pc     = in_pc;
    assign in_entry_s.result = in_result;
    assign in_entry_s.rob_id = in_rob_id;

    // Next occupancy from the push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and the registered stall/valid decodes of the next occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r  <= '0;
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            stall_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            stall_r <= (count_nxt_s == DEPTH_C);
            valid_r <= (count_nxt_s != CNT_W'(0));
        end
    end

    // Entry storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // Head read, forced to zero while empty
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (valid_r) begin
            out_s = head_s;
        end else begin
            out_s = '0;
        end
    end

    assign stall_out = stall_r;
    assign wb_valid  = valid_r;
    assign wb_type   = out_s.typ;
    assign wb_pc     = out_s.pc;
    assign wb_result = out_s.result;
    assign wb_rob_id = out_s.rob_id;

`ifdef MUL_WB_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_wb_r;

    // Saturating stall-cycle and pop counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_r <= 32'h0000_0000;
            perf_wb_r    <= 32'h0000_0000;
        end else begin
            if (stall_r && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'h0000_0001;
            end
            if (pop_s && (perf_wb_r != 32'hFFFF_FFFF)) begin
                perf_wb_r <= perf_wb_r + 32'h0000_0001;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_wb_count     = perf_wb_r;
`else
    // No performance counters in this build
`endif

endmodule

// File: tb/tb_mul_m5_writeback.sv
// Self-checking bench for mul_m5_writeback: explicit per-cycle vector table plus a queue scoreboard.
// Build with MUL_WB_PERF_EN defined to also check the perf counters.
module tb_mul_m5_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_type;
    logic [31:0] in_pc;
    logic [31:0] in_result;
    logic [2:0]  in_rob_id;
    logic        stall_out;
    logic        wb_valid;
    logic [1:0]  wb_type;
    logic [31:0] wb_pc;
    logic [31:0] wb_result;
    logic [2:0]  wb_rob_id;
    logic        wb_ready;
`ifdef MUL_WB_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_wb_count;
`endif

    mul_m5_writeback #(
        .WORD_SIZE(32), .INSTR_TYPE_SZ(2), .ROB_ENTRY_WIDTH(3), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_type(in_type), .in_pc(in_pc),
        .in_result(in_result), .in_rob_id(in_rob_id),
        .stall_out(stall_out),
        .wb_valid(wb_valid), .wb_type(wb_type), .wb_pc(wb_pc),
        .wb_result(wb_result), .wb_rob_id(wb_rob_id),
`ifdef MUL_WB_PERF_EN
        .perf_stall_cycles(perf_stall_cycles), .perf_wb_count(perf_wb_count),
`endif
        .wb_ready(wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] pc;
        logic [31:0] res;
        logic [2:0]  rob;
    } ent_t;

    typedef struct {
        bit          v;
        logic [2:0]  rob;
        logic [31:0] res;
        bit          rdy;
        bit          e_stall;
        bit          e_valid;
        logic [2:0]  e_rob;
        logic [31:0] e_res;
    } vec_t;

    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   max_occ = 0;
    int   stall_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input logic [2:0] rob, input logic [31:0] res,
                          input logic [31:0] pc, input logic [1:0] typ, input bit rdy);
        in_valid  = v;
        in_rob_id = rob;
        in_result = res;
        in_pc     = pc;
        in_type   = typ;
        wb_ready  = rdy;
    endtask

    // Check outputs against the scoreboard, then advance one clock and update the model
    task automatic cycle();
        bit   push;
        bit   pop;
        ent_t e;
        check("stall_out", {63'd0, stall_out}, {63'd0, sb.size() == DEPTH});
        check("wb_valid", {63'd0, wb_valid}, {63'd0, sb.size() != 0});
        if (stall_out) stall_seen++;
        if (sb.size() != 0) begin
            check("wb_rob_id", {61'd0, wb_rob_id}, {61'd0, sb[0].rob});
            check("wb_result", {32'd0, wb_result}, {32'd0, sb[0].res});
            check("wb_pc", {32'd0, wb_pc}, {32'd0, sb[0].pc});
            check("wb_type", {62'd0, wb_type}, {62'd0, sb[0].typ});
        end else begin
            check("wb_zero", {wb_type, wb_pc, wb_result, wb_rob_id}, 69'd0);
        end
        push = in_valid && (sb.size() != DEPTH);
        pop  = wb_ready && (sb.size() != 0);
        e = '{typ: in_type, pc: in_pc, res: in_result, rob: in_rob_id};
        @(posedge clk);
        #1;
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back(e);
        if (sb.size() > max_occ) max_occ = sb.size();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 3'd3, 32'h6,  1'b1, 1'b0, 1'b0, 3'd0, 32'h0};
        tbl[1]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b1, 3'd3, 32'h6};
        tbl[2]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b0, 3'd0, 32'h0};
        tbl[3]  = '{1'b1, 3'd1, 32'hA1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0};
        tbl[4]  = '{1'b1, 3'd2, 32'hA2, 1'b0, 1'b0, 1'b1, 3'd1, 32'hA1};
        tbl[5]  = '{1'b1, 3'd4, 32'hA4, 1'b0, 1'b1, 1'b1, 3'd1, 32'hA1};
        tbl[6]  = '{1'b1, 3'd4, 32'hA4, 1'b1, 1'b1, 1'b1, 3'd1, 32'hA1};
        tbl[7]  = '{1'b1, 3'd4, 32'hA4, 1'b0, 1'b0, 1'b1, 3'd2, 32'hA2};
        tbl[8]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b1, 1'b1, 3'd2, 32'hA2};
        tbl[9]  = '{1'b0, 3'd0, 32'h0,  1'b1, 1'b0, 1'b1, 3'd4, 32'hA4};
        tbl[10] = '{1'b0, 3'd0, 32'h0,  1'b0, 1'b0, 1'b0, 3'd0, 32'h0};

        set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("reset_stall", {63'd0, stall_out}, 64'd0);
        check("reset_wb_rob_id", {61'd0, wb_rob_id}, 64'd0);

        // Single op followed by fill / held third input / drain
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].v, tbl[i].rob, tbl[i].res, 32'h4000 + 32'(tbl[i].rob),
                   tbl[i].rob[1:0], tbl[i].rdy);
            check($sformatf("vec%0d_stall", i), {63'd0, stall_out}, {63'd0, tbl[i].e_stall});
            check($sformatf("vec%0d_valid", i), {63'd0, wb_valid}, {63'd0, tbl[i].e_valid});
            check($sformatf("vec%0d_rob", i), {61'd0, wb_rob_id}, {61'd0, tbl[i].e_rob});
            check($sformatf("vec%0d_res", i), {32'd0, wb_result}, {32'd0, tbl[i].e_res});
            cycle();
        end

        // Streaming at full rate: stall must never assert
        stall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 3'(i), $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
            cycle();
        end
        set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1);
        repeat (2) cycle();
        check("stream_no_stall", 64'(stall_seen), 64'd0);

        // Alternating push/pop across the pointer wrap
        max_occ = 0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 3'(i + 2), 32'hB0 + 32'(i), 32'h8000 + 32'(i), 2'(i), 1'b0);
            cycle();
            set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1);
            cycle();
        end
        check("wrap_max_occ", 64'(max_occ), 64'd1);
        check("wrap_drained", {63'd0, wb_valid}, 64'd0);

        // Reset while FULL drops everything
        set_in(1'b1, 3'd5, 32'hC5, 32'hC500, 2'd1, 1'b0);
        cycle();
        set_in(1'b1, 3'd6, 32'hC6, 32'hC600, 2'd2, 1'b0);
        cycle();
        check("full_before_reset", {63'd0, stall_out}, 64'd1);
        set_in(1'b1, 3'd7, 32'hC7, 32'hC700, 2'd3, 1'b0);
        do_reset();
        check("midreset_valid", {63'd0, wb_valid}, 64'd0);
        check("midreset_stall", {63'd0, stall_out}, 64'd0);
        check("midreset_wb", {wb_type, wb_pc, wb_result, wb_rob_id}, 69'd0);
        set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1);
        repeat (3) cycle();
        set_in(1'b1, 3'd1, 32'hD1, 32'hD100, 2'd1, 1'b1);
        cycle();
        set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1);
        repeat (2) cycle();

`ifdef MUL_WB_PERF_EN
        do_reset();
        check("perf_reset_stall", 64'(perf_stall_cycles), 64'd0);
        check("perf_reset_wb", 64'(perf_wb_count), 64'd0);
        set_in(1'b1, 3'd1, 32'hE1, 32'hE100, 2'd0, 1'b0);
        cycle();
        set_in(1'b1, 3'd2, 32'hE2, 32'hE200, 2'd0, 1'b0);
        cycle();
        set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b0);
        repeat (3) cycle();
        set_in(1'b0, 3'd0, 32'h0, 32'h0, 2'd0, 1'b1);
        repeat (3) cycle();
        check("perf_stall_cycles", 64'(perf_stall_cycles), 64'd4);
        check("perf_wb_count", 64'(perf_wb_count), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
